// File: rtl/mul_unit_if.sv
// Operand/request and register-bank write-port bundle for mul_unit.
// The master drives the request, the slave (mul_unit) returns the result.
interface mul_unit_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          start;
  logic          acc_en;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] acc;
  logic [AW-1:0] dest;
  logic          flush;
  logic          busy;
  logic          done;
  logic          err;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  modport master (
    output start, acc_en, a, b, acc, dest, flush,
    input  busy, done, err, we3, wa3, wd3
  );

  modport slave (
    input  start, acc_en, a, b, acc, dest, flush,
    output busy, done, err, we3, wa3, wd3
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative 32-cycle shift-add multiply / multiply-accumulate, low 32 bits.
// Result is returned on the register bank write port during a one-cycle WB state.
module mul_unit (
  input logic       clk,
  input logic       rst,
  mul_unit_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] prod_q, prod_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] dest_q, dest_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;

  logic accept;
  logic last_iter;

  assign accept    = bus.start && !bus.flush;
  assign last_iter = (count_q == CW'(DW - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (bus.flush)      state_d = IDLE;
        else if (last_iter) state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    count_d  = count_q;
    dest_d   = dest_q;
    busy_d   = (state_d != IDLE);
    done_d   = 1'b0;
    err_d    = 1'b0;
    we3_d    = 1'b0;
    wa3_d    = '0;
    wd3_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          dest_d   = bus.dest;
          prod_d   = bus.acc_en ? bus.acc : '0;
          count_d  = '0;
        end
      end
      RUN: begin
        if (!bus.flush) begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          // Final iteration loads the WB outputs with the completed product
          if (last_iter) begin
            done_d = 1'b1;
            if (dest_q == AW'(4'hF)) begin
              err_d = 1'b1;
            end else begin
              we3_d = 1'b1;
              wa3_d = dest_q;
              wd3_d = prod_d;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      dest_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      dest_q   <= dest_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.we3  = we3_q;
  assign bus.wa3  = wa3_q;
  assign bus.wd3  = wd3_q;
endmodule
